wallace_adder: RTL and testbench

Three-operand unsigned adder built as a Wallace/carry-save reduction. One row of full adders compresses A+B+C into a sum vector and a carry vector, and a carry-propagate adder then produces the final sum. The block is pipelined over two register stages with a valid qualifier, and sits in datapaths that need to accumulate three partial values per cycle.

---
 rtl/wallace_adder_full_adder.sv | 17 +
 rtl/wallace_adder.sv | 85 ++++++++
 tb/tb_wallace_adder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wallace_adder_full_adder.sv
// One-bit full adder cell.
// Shared by the carry-save row and the ripple carry-propagate adder.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum is the parity of the three inputs, carry is their majority.
  always_comb begin
    sum  = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
  end

endmodule

// File: rtl/wallace_adder.sv
// Three-operand unsigned adder: carry-save row, then a ripple CPA.
// Two register stages with a valid flag riding alongside the data.
module wallace_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH+1:0] s
);

  localparam int OW = WIDTH + 2;

  logic [WIDTH-1:0] ps_d;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] ps_q;
  logic [WIDTH-1:0] pc_q;
  logic             v1_q;

  logic [WIDTH:0]   psx;
  logic [WIDTH:0]   rc;
  logic [OW-1:0]    s_d;
  logic [OW-1:0]    s_q;
  logic             ov_q;

  // Carry-save row: pc[i] carries weight 2^(i+1).
  for (genvar i = 0; i < WIDTH; i++) begin : g_csa
    full_adder u_fa (
      .x    (a[i]),
      .y    (b[i]),
      .cin  (c[i]),
      .sum  (ps_d[i]),
      .cout (pc_d[i])
    );
  end

  // Stage 1 holds the sum and carry vectors; not gated by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
      pc_q <= '0;
      v1_q <= 1'b0;
    end else begin
      ps_q <= ps_d;
      pc_q <= pc_d;
      v1_q <= in_valid;
    end
  end

  assign psx   = {1'b0, ps_q};
  assign rc[0] = 1'b0;

  // Ripple CPA over bits 1..WIDTH; bit 0 has no carry partner.
  for (genvar i = 1; i <= WIDTH; i++) begin : g_cpa
    full_adder u_fa (
      .x    (psx[i]),
      .y    (pc_q[i-1]),
      .cin  (rc[i-1]),
      .sum  (s_d[i]),
      .cout (rc[i])
    );
  end

  assign s_d[0]    = ps_q[0];
  assign s_d[OW-1] = rc[WIDTH];

  // Stage 2 holds the final sum and the delayed valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      ov_q <= v1_q;
    end
  end

  assign s         = s_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_wallace_adder.sv
// Self-checking bench for wallace_adder at WIDTH=4 and WIDTH=8.
// Directed cases, async reset, then random vectors against a queue model.
module tb_wallace_adder;

  logic       clk;
  logic       rst_n;
  logic       vin;
  logic [3:0] a4, b4, c4;
  logic [7:0] a8, b8, c8;
  logic       ov4, ov8;
  logic [5:0] s4;
  logic [9:0] s8;

  int n_assert;
  int n_fail;

  typedef struct {
    logic        v;
    int unsigned e4;
    int unsigned e8;
  } item_t;

  item_t q[$];

  wallace_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vin),
    .a         (a4),
    .b         (b4),
    .c         (c4),
    .out_valid (ov4),
    .s         (s4)
  );

  wallace_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vin),
    .a         (a8),
    .b         (b8),
    .c         (c8),
    .out_valid (ov8),
    .s         (s8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y,
                       input int z);
    vin = v;
    a4 = 4'(x); b4 = 4'(y); c4 = 4'(z);
    a8 = 8'(x); b8 = 8'(y); c8 = 8'(z);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b1, int'($urandom_range(15)), int'($urandom_range(15)),
          int'($urandom_range(15)));
    step();
    drive(1'b1, int'($urandom_range(15)), int'($urandom_range(15)),
          int'($urandom_range(15)));
    step();
    step();
    chk("rst_s4", 32'(s4), 0);
    chk("rst_ov4", 32'(ov4), 0);
    chk("rst_s8", 32'(s8), 0);
    chk("rst_ov8", 32'(ov8), 0);

    drive(1'b0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_ov4", 32'(ov4), 0);

    // Basic
    drive(1'b1, 1, 2, 4);
    step();
    drive(1'b0, 0, 0, 0);
    step();
    chk("basic_s4", 32'(s4), 7);
    chk("basic_ov4", 32'(ov4), 1);
    chk("basic_s8", 32'(s8), 7);
    step();
    chk("basic_ov4_drop", 32'(ov4), 0);

    // Mixed carries
    drive(1'b1, 9, 12, 15);
    step();
    drive(1'b0, 0, 0, 0);
    step();
    chk("mixed_s4", 32'(s4), 36);
    chk("mixed_ov4", 32'(ov4), 1);

    // Max and zero operands
    drive(1'b1, 15, 15, 15);
    step();
    drive(1'b1, 0, 0, 0);
    step();
    chk("max_s4", 32'(s4), 45);
    chk("max_s8", 32'(s8), 45);
    drive(1'b0, 0, 0, 0);
    step();
    chk("zero_s4", 32'(s4), 0);
    chk("zero_ov4", 32'(ov4), 1);
    step();

    // Back-to-back
    drive(1'b1, 1, 2, 4);
    step();
    drive(1'b1, 9, 12, 15);
    step();
    chk("b2b0_s4", 32'(s4), 7);
    chk("b2b0_ov4", 32'(ov4), 1);
    drive(1'b1, 15, 15, 15);
    step();
    chk("b2b1_s4", 32'(s4), 36);
    chk("b2b1_ov4", 32'(ov4), 1);
    drive(1'b0, 0, 0, 0);
    step();
    chk("b2b2_s4", 32'(s4), 45);
    chk("b2b2_ov4", 32'(ov4), 1);
    step();
    chk("b2b_end_ov4", 32'(ov4), 0);

    // Asynchronous reset between edges discards in-flight work
    drive(1'b1, 15, 15, 15);
    step();
    drive(1'b1, 1, 2, 4);
    step();
    chk("pre_arst_s4", 32'(s4), 45);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s4", 32'(s4), 0);
    chk("arst_ov4", 32'(ov4), 0);
    chk("arst_s8", 32'(s8), 0);
    chk("arst_ov8", 32'(ov8), 0);
    step();
    drive(1'b0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk("arst_flush1_ov8", 32'(ov8), 0);
    step();
    chk("arst_flush2_ov8", 32'(ov8), 0);

    // Random vectors with valid gaps; model = plain sum, 2-cycle queue
    for (int i = 0; i < 1002; i++) begin
      item_t it;
      if (i < 1000) begin
        vin = 1'($urandom_range(3) != 0);
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        c8  = 8'($urandom);
      end else begin
        vin = 1'b0;
        a8 = '0; b8 = '0; c8 = '0;
      end
      a4 = a8[3:0];
      b4 = b8[3:0];
      c4 = c8[3:0];
      it.v  = vin;
      it.e8 = int'(a8) + int'(b8) + int'(c8);
      it.e4 = int'(a4) + int'(b4) + int'(c4);
      q.push_back(it);
      step();
      if (q.size() == 2) begin
        item_t ex;
        ex = q.pop_front();
        chk("rnd_ov8", 32'(ov8), 32'(ex.v));
        chk("rnd_ov4", 32'(ov4), 32'(ex.v));
        if (ex.v) begin
          chk("rnd_s8", 32'(s8), ex.e8);
          chk("rnd_s4", 32'(s4), ex.e4);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
